// File: rtl/mips_pkg.sv
// Shared MIPS-I decode constants: opcodes, R-type functs, REGIMM rt codes,
// the control-flag bundle and the ALUControl selection helper.
package mips_pkg;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LWL    = 6'h22;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LWR    = 6'h26;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SWL    = 6'h2A;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_SWR    = 6'h2E;
  localparam logic [5:0] OP_LL     = 6'h30;
  localparam logic [5:0] OP_SC     = 6'h38;

  // R-type function codes (Instr[5:0]) that change the default R-type controls
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  // REGIMM rt field selections (Instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

  // Control flags produced by the decoder; all-zero is a NOP.
  typedef struct packed {
    logic link;
    logic reg_dest;
    logic jump;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic jump_register;
    logic sign_or_zero;
    logic syscall;
  } ctrl_t;

  // The ALU is steered by the funct field for R-type and by the opcode otherwise.
  function automatic logic [5:0] alu_code(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_RTYPE) ? funct : opcode;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Pure-combinational MIPS-I control decoder. Unknown encodings leave every
// flag at 0 so they behave as a NOP downstream.
module id_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic [5:0] alu_control
);

  // Flag decode: defaults first, then the per-opcode overrides.
  always_comb begin
    ctrl        = '0;
    alu_control = alu_code(opcode, funct);
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dest  = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_JR: begin
            ctrl.jump          = 1'b1;
            ctrl.jump_register = 1'b1;
            ctrl.reg_write     = 1'b0;
          end
          FN_JALR: begin
            ctrl.jump          = 1'b1;
            ctrl.jump_register = 1'b1;
            ctrl.link          = 1'b1;
          end
          FN_SYSCALL: begin
            ctrl.syscall   = 1'b1;
            ctrl.reg_write = 1'b0;
          end
          default: ;
        endcase
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl.branch       = 1'b1;
        ctrl.sign_or_zero = 1'b1;
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: begin
            ctrl.branch       = 1'b1;
            ctrl.sign_or_zero = 1'b1;
          end
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl.branch       = 1'b1;
            ctrl.sign_or_zero = 1'b1;
            ctrl.link         = 1'b1;
            ctrl.reg_write    = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.alu_src      = 1'b1;
        ctrl.reg_write    = 1'b1;
        ctrl.sign_or_zero = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_LL: begin
        ctrl.mem_read     = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.reg_write    = 1'b1;
        ctrl.sign_or_zero = 1'b1;
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        ctrl.mem_write    = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.sign_or_zero = 1'b1;
      end
      OP_SC: begin
        ctrl.mem_write    = 1'b1;
        ctrl.alu_src      = 1'b1;
        ctrl.sign_or_zero = 1'b1;
        ctrl.reg_write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_decode_unit.sv
// ID-stage decode core: control decoder, 32x32 register file with three
// combinational read ports, and the branch/jump target calculator.
// Reads do not bypass a same-cycle write; the ID stage owns forwarding.
module id_decode_unit
  import mips_pkg::*;
#(
  parameter TAG = "1"
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] Instr_PC_Plus4,
  input  logic [31:0] RegValue,
  input  logic [4:0]  RegC,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic        Write,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  output logic [31:0] DataC,
  output logic [31:0] NextAddr,
  output logic        Link,
  output logic        RegDest,
  output logic        Jump,
  output logic        Branch,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        JumpRegister,
  output logic        SignOrZero,
  output logic        Syscall,
  output logic [5:0]  ALUControl
);

  // TAG is a debug label only; an empty tag simply yields an empty scope.
  if ($bits(TAG) == 0) begin : g_untagged
  end

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] branch_offset;
  logic [31:0] regs [32];
  ctrl_t       ctrl;

  assign rs = Instr[25:21];
  assign rt = Instr[20:16];

  id_decoder u_decoder (
    .opcode      (Instr[31:26]),
    .rt          (rt),
    .funct       (Instr[5:0]),
    .ctrl        (ctrl),
    .alu_control (ALUControl)
  );

  assign Link         = ctrl.link;
  assign RegDest      = ctrl.reg_dest;
  assign Jump         = ctrl.jump;
  assign Branch       = ctrl.branch;
  assign MemRead      = ctrl.mem_read;
  assign MemWrite     = ctrl.mem_write;
  assign ALUSrc       = ctrl.alu_src;
  assign RegWrite     = ctrl.reg_write;
  assign JumpRegister = ctrl.jump_register;
  assign SignOrZero   = ctrl.sign_or_zero;
  assign Syscall      = ctrl.syscall;

  // Register file write port: async clear, r0 is never written.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (Write && (WriteReg != 5'd0)) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Read ports: r0 forced to zero, no write-through.
  always_comb begin
    DataA = (rs   == 5'd0) ? 32'd0 : regs[rs];
    DataB = (rt   == 5'd0) ? 32'd0 : regs[rt];
    DataC = (RegC == 5'd0) ? 32'd0 : regs[RegC];
  end

  // Word-aligned, sign-extended branch displacement.
  assign branch_offset = {{14{Instr[15]}}, Instr[15:0], 2'b00};

  // Target select: register jump, then region jump, else PC-relative branch.
  always_comb begin
    NextAddr = Instr_PC_Plus4 + branch_offset;
    if (ctrl.jump_register) begin
      NextAddr = RegValue;
    end else if (ctrl.jump) begin
      NextAddr = {Instr_PC_Plus4[31:28], Instr[25:0], 2'b00};
    end
  end

endmodule

// File: tb/tb_id_decode_unit.sv
// Directed bench for id_decode_unit: register-file reset/write/read behaviour,
// control decode and next-address computation, scored through an expected queue.
module tb_id_decode_unit;

  localparam int W = 145;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr;
  logic [31:0] Instr_PC_Plus4;
  logic [31:0] RegValue;
  logic [4:0]  RegC;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Write;
  logic [31:0] DataA, DataB, DataC, NextAddr;
  logic        Link, RegDest, Jump, Branch, MemRead, MemWrite;
  logic        ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall;
  logic [5:0]  ALUControl;

  id_decode_unit #(.TAG("1")) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .Instr          (Instr),
    .Instr_PC_Plus4 (Instr_PC_Plus4),
    .RegValue       (RegValue),
    .RegC           (RegC),
    .WriteReg       (WriteReg),
    .WriteData      (WriteData),
    .Write          (Write),
    .DataA          (DataA),
    .DataB          (DataB),
    .DataC          (DataC),
    .NextAddr       (NextAddr),
    .Link           (Link),
    .RegDest        (RegDest),
    .Jump           (Jump),
    .Branch         (Branch),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .ALUSrc         (ALUSrc),
    .RegWrite       (RegWrite),
    .JumpRegister   (JumpRegister),
    .SignOrZero     (SignOrZero),
    .Syscall        (Syscall),
    .ALUControl     (ALUControl)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Flag bit positions inside the packed observation word
  localparam logic [10:0] F_LINK = 11'h400;
  localparam logic [10:0] F_RDST = 11'h200;
  localparam logic [10:0] F_JUMP = 11'h100;
  localparam logic [10:0] F_BR   = 11'h080;
  localparam logic [10:0] F_MRD  = 11'h040;
  localparam logic [10:0] F_MWR  = 11'h020;
  localparam logic [10:0] F_ASRC = 11'h010;
  localparam logic [10:0] F_RWR  = 11'h008;
  localparam logic [10:0] F_JR   = 11'h004;
  localparam logic [10:0] F_SOZ  = 11'h002;
  localparam logic [10:0] F_SYS  = 11'h001;

  localparam logic [W-1:0] MASK_REGS = {{96{1'b1}}, {49{1'b0}}};
  localparam logic [W-1:0] MASK_CTL  = {{96{1'b0}}, {49{1'b1}}};

  logic [W-1:0] obs;
  assign obs = {DataA, DataB, DataC, NextAddr, ALUControl,
                Link, RegDest, Jump, Branch, MemRead, MemWrite,
                ALUSrc, RegWrite, JumpRegister, SignOrZero, Syscall};

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic expect_regs(input string n, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
    exp_q.push_back({a, b, c, 49'd0});
    mask_q.push_back(MASK_REGS);
    name_q.push_back(n);
  endtask

  task automatic expect_ctl(input string n, input logic [31:0] na,
                            input logic [5:0] alu, input logic [10:0] f);
    exp_q.push_back({96'd0, na, alu, f});
    mask_q.push_back(MASK_CTL);
    name_q.push_back(n);
  endtask

  // Monitor: outputs are combinational, so every pending entry is sampled
  // on the falling edge following the stimulus.
  always @(negedge CLK) begin
    logic [W-1:0] e;
    logic [W-1:0] m;
    string        n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (((obs ^ e) & m) != '0) begin
        failures++;
        $display("FAIL %s: actual=%h required=%h", n, obs & m, e & m);
      end
    end
  end

  // Advance to just after the next rising edge; anything still queued was never sampled.
  task automatic step();
    @(posedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected entries not sampled", exp_q.size());
      exp_q.delete();
      mask_q.delete();
      name_q.delete();
    end
  endtask

  task automatic vec(input string n, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [31:0] rv, input logic [31:0] na,
                     input logic [5:0] alu, input logic [10:0] f);
    Instr          = ins;
    Instr_PC_Plus4 = pc;
    RegValue       = rv;
    expect_ctl(n, na, alu, f);
    step();
  endtask

  initial begin
    RESET          = 1'b1;
    Instr          = '0;
    Instr_PC_Plus4 = '0;
    RegValue       = '0;
    RegC           = '0;
    WriteReg       = '0;
    WriteData      = '0;
    Write          = 1'b0;
    #2 RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Every register reads zero while reset is held
    for (int r = 0; r < 32; r++) begin
      logic [4:0] r5;
      r5    = 5'(r);
      Instr = {6'h00, r5, r5, 16'h0000};
      RegC  = r5;
      expect_regs($sformatf("reset_r%0d", r), 32'd0, 32'd0, 32'd0);
      step();
    end
    RESET = 1'b1;
    step();

    // Same-cycle read sees the old value, new value after the edge
    Write = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
    Instr = 32'h00A00000; RegC = 5'd5;
    expect_regs("r5_same_cycle", 32'd0, 32'd0, 32'd0);
    step();
    Write = 1'b0;
    expect_regs("r5_written", 32'hDEADBEEF, 32'd0, 32'hDEADBEEF);
    step();

    // Writes to r0 are discarded
    Write = 1'b1; WriteReg = 5'd0; WriteData = 32'h00001234;
    Instr = 32'h00050000; RegC = 5'd0;
    expect_regs("r0_same_cycle", 32'd0, 32'hDEADBEEF, 32'd0);
    step();
    Write = 1'b0;
    expect_regs("r0_stays_zero", 32'd0, 32'hDEADBEEF, 32'd0);
    step();

    // Highest register through all three ports; Write=0 blocks an update
    Write = 1'b1; WriteReg = 5'd31; WriteData = 32'h80000001;
    step();
    Write = 1'b0; WriteReg = 5'd5; WriteData = 32'h11111111;
    Instr = 32'h03E50000; RegC = 5'd31;
    step();
    expect_regs("write_disabled", 32'h80000001, 32'hDEADBEEF, 32'h80000001);
    step();

    // Asynchronous reset mid-operation clears contents before any edge
    RESET = 1'b0;
    expect_regs("async_reset_clear", 32'd0, 32'd0, 32'd0);
    step();
    RESET = 1'b1;
    step();

    // Decode and next-address vectors
    vec("beq_back",   32'h1000FFFF, 32'h00000100, 32'h0,        32'h000000FC, 6'h04, F_BR | F_SOZ);
    vec("jal",        32'h0C100000, 32'h40000004, 32'h0,        32'h40400000, 6'h03, F_JUMP | F_LINK | F_RWR);
    vec("jr",         32'h03E00008, 32'h00000100, 32'h00400020, 32'h00400020, 6'h08, F_JUMP | F_JR | F_RDST);
    vec("syscall",    32'h0000000C, 32'h00000100, 32'h0,        32'h00000130, 6'h0C, F_RDST | F_SYS);
    vec("lw",         32'h8C820004, 32'h00000100, 32'h0,        32'h00000110, 6'h23, F_MRD | F_ASRC | F_RWR | F_SOZ);
    vec("jalr",       32'h0060F809, 32'h00000100, 32'h12345678, 32'h12345678, 6'h09, F_JUMP | F_JR | F_LINK | F_RDST | F_RWR);
    vec("j",          32'h08000010, 32'hF0000004, 32'h0,        32'hF0000040, 6'h02, F_JUMP);
    vec("bltzal",     32'h04108000, 32'h00010000, 32'h0,        32'hFFFF0000, 6'h01, F_BR | F_SOZ | F_LINK | F_RWR);
    vec("bgez",       32'h04010001, 32'h00000100, 32'h0,        32'h00000104, 6'h01, F_BR | F_SOZ);
    vec("bgezal",     32'h04110000, 32'h00000100, 32'h0,        32'h00000100, 6'h01, F_BR | F_SOZ | F_LINK | F_RWR);
    vec("regimm_bad", 32'h04020000, 32'h00000100, 32'h0,        32'h00000100, 6'h01, 11'h000);
    vec("ori",        32'h34A5FFFF, 32'h00000100, 32'h0,        32'h000000FC, 6'h0D, F_ASRC | F_RWR);
    vec("addiu",      32'h24A50001, 32'h00000100, 32'h0,        32'h00000104, 6'h09, F_ASRC | F_RWR | F_SOZ);
    vec("lui",        32'h3C011234, 32'h00000000, 32'h0,        32'h000048D0, 6'h0F, F_ASRC | F_RWR);
    vec("sb",         32'hA0A10000, 32'h00000100, 32'h0,        32'h00000100, 6'h28, F_MWR | F_ASRC | F_SOZ);
    vec("sc",         32'hE0A10000, 32'h00000100, 32'h0,        32'h00000100, 6'h38, F_MWR | F_ASRC | F_SOZ | F_RWR);
    vec("ll",         32'hC0A10000, 32'h00000100, 32'h0,        32'h00000100, 6'h30, F_MRD | F_ASRC | F_RWR | F_SOZ);
    vec("add",        32'h00A62020, 32'h00000100, 32'h0,        32'h00008180, 6'h20, F_RDST | F_RWR);
    vec("op_3f_nop",  32'hFC000000, 32'h00000100, 32'h0,        32'h00000100, 6'h3F, 11'h000);
    vec("op_27_nop",  32'h9C000000, 32'h00000100, 32'h0,        32'h00000100, 6'h27, 11'h000);
    vec("op_2c_nop",  32'hB0000000, 32'h00000100, 32'h0,        32'h00000100, 6'h2C, 11'h000);
    vec("bgtz_wrap",  32'h1CA07FFF, 32'hFFFFFFF0, 32'h0,        32'h0001FFEC, 6'h07, F_BR | F_SOZ);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
